ttt_turn_controller: RTL and testbench
======================================

Name: ttt_turn_controller

Overview:
- Sequences a two-player tic-tac-toe game.
- Owns the 3x3 board register and drives pos1..pos9 to the move-legality checker.
- Samples that checker's combinational illegal flag when a player confirms a move, commits legal moves and alternates turns.
- Detects win or draw, and blanks the indicators for a fixed time after an illegal attempt.

Parameters:
- ERR_CYCLES, 50000000, number of clk cycles the illegal indicator stays asserted after a rejected move.
- ERR_W, 26, width of the error-hold counter; must satisfy 2^ERR_W > ERR_CYCLES.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- cur_pos  input  9  one-hot cursor position, bit0 = square 1 ... bit8 = square 9.
- confirm  input  1  single-cycle pulse (debounced upstream) requesting placement at cur_pos.
- illegal  input  1  from legality checker, valid the same cycle as cur_pos/pos1..pos9.
- new_game  input  1  single-cycle pulse; restarts the game from any state.
- pos1..pos9  output  2 each  board contents: 0 empty, 1 player1, 2 player2; 3 never driven.
- player1  output  1  high while waiting for player1's move.
- player2  output  1  high while waiting for player2's move.
- illegal_led  output  1  high during the error-hold window.
- game_over  output  1  high in DONE.
- winner  output  2  0 none/draw, 1 player1, 2 player2; valid when game_over.
- draw  output  1  high in DONE with no winner.
- move_cnt  output  4  number of committed moves, 0..9.

Behaviour:
- Reset (reset=0): all posN=0, move_cnt=0, winner=0, draw=0, game_over=0, illegal_led=0, err counter=0. State=P1_WAIT, so player1=1 and player2=0.
- States: P1_WAIT, P2_WAIT, EVAL, ERR, DONE. A last_player register (1 bit) records who moved.
- PX_WAIT with confirm=1 and illegal=1:
  - go to ERR; load err counter with ERR_CYCLES-1; illegal_led=1 from next cycle.
  - board and move_cnt unchanged.
  - return state = the same player's WAIT.
- PX_WAIT with confirm=1 and illegal=0:
  - next edge writes X's code into the single square selected by cur_pos; move_cnt+1.
  - last_player=X; go to EVAL.
- PX_WAIT with confirm=0: hold.
- EVAL (one cycle): evaluates the 8 lines (rows 123/456/789, columns 147/258/369, diagonals 159/357) against last_player's code.
  - any line complete -> DONE, winner=code.
  - else move_cnt==9 -> DONE, draw=1.
  - else -> other player's WAIT.
- Latency: confirm sampled at edge N; board/move_cnt visible after N; turn/game_over outputs change after N+1.
- ERR:
  - counter decrements each cycle; at 0 -> illegal_led=0, return to the saved WAIT state.
  - player1/player2 both 0 during ERR.
  - confirm ignored.
- player1/player2 are Moore outputs, high only in the respective WAIT state. They are never both high.
- DONE:
  - board, winner, draw and move_cnt frozen; confirm ignored; game_over=1; player1=player2=0.
- new_game=1 in any state (highest priority over confirm, same edge):
  - clear board, move_cnt, winner, draw and illegal_led; zero err counter.
  - go to P1_WAIT.
  - player1 always starts.
- Defensive rules:
  - cur_pos not one-hot with confirm: the checker flags it illegal; the controller additionally treats non-one-hot as illegal regardless of the illegal input.
  - An occupied square is never overwritten.
- Asynchronous reset mid-EVAL or mid-ERR returns to reset values with no partial commit.

Decomposition:
- Shared package ttt_pkg:
  - cell codes CELL_EMPTY=2'd0, CELL_P1=2'd1, CELL_P2=2'd2.
  - state encoding localparams.
  - the 8 win-line index triples.
- One natural sub-module: ttt_win_detect. Combinational; inputs 9x2-bit board and a 2-bit code; outputs 1-bit line_complete. Instantiated once in EVAL logic.

Test Plan:
- Reset release -> player1=1, all posN=0, move_cnt=0, game_over=0; confirm at cur_pos=9'h001 with illegal=0 -> pos1=1, player2=1 two cycles later.
- Player2 confirms cur_pos=9'h001 with illegal=1 (ERR_CYCLES=4 for sim) -> illegal_led high exactly 4 cycles, player2 returns to 1, pos1 still 1, move_cnt=1.
- P1 plays squares 1, 5, 9 interleaved with P2 on 2, 3 -> after the fifth move: game_over=1, winner=1, draw=0, move_cnt=5; later confirm pulses change nothing.
- Full board with no line (P1: 1, 3, 4, 8, 9; P2: 2, 5, 6, 7) -> move_cnt=9, draw=1, winner=0, game_over=1.
- new_game asserted in the same cycle as confirm during P2_WAIT -> board cleared, player1=1, no commit; new_game during ERR -> illegal_led=0 next cycle.
- Confirm with cur_pos=9'h003 and illegal=0 forced -> treated as illegal, ERR entered, board unchanged. reset pulsed low during EVAL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: cell codes,
// controller states and the eight winning lines.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;

  typedef enum logic [2:0] {
    StP1Wait = 3'd0,
    StP2Wait = 3'd1,
    StEval   = 3'd2,
    StErr    = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Board square N (1..9) lives at index N-1.
  typedef logic [8:0][1:0] board_t;

  localparam int unsigned NUM_LINES = 8;

  // Zero-based square indices of rows, columns and diagonals.
  localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Player select bit (0 = player1, 1 = player2) to cell code.
  function automatic logic [1:0] player_code(input logic p2);
    return p2 ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational three-in-a-row detector for one player code.
module ttt_win_detect
  import ttt_pkg::*;
(
  input  board_t     board,
  input  logic [1:0] code,
  output logic       line_complete
);

  logic [NUM_LINES-1:0] line_hit;

  for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
    assign line_hit[l] = (board[WIN_LINES[l][0]] == code) &&
                         (board[WIN_LINES[l][1]] == code) &&
                         (board[WIN_LINES[l][2]] == code);
  end

  // An empty code must never report a "win" on empty lines.
  always_comb begin
    line_complete = (code != CELL_EMPTY) && (|line_hit);
  end

endmodule

// File: rtl/ttt_turn_controller.sv
// Two-player tic-tac-toe sequencer: owns the board, commits legal moves,
// alternates turns, detects win/draw and holds an error window after
// rejected moves.
module ttt_turn_controller
  import ttt_pkg::*;
#(
  parameter int unsigned ERR_CYCLES = 50000000,
  parameter int unsigned ERR_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] cur_pos,
  input  logic       confirm,
  input  logic       illegal,
  input  logic       new_game,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic       player1,
  output logic       player2,
  output logic       illegal_led,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw,
  output logic [3:0] move_cnt
);

  localparam logic [ERR_W-1:0] ERR_LOAD = ERR_W'(ERR_CYCLES - 1);

  state_e           state_q, state_d;
  board_t           board_q, board_d, board_placed;
  logic [3:0]       move_cnt_q, move_cnt_d;
  logic             last_q, last_d;   // 0 = player1, 1 = player2
  logic             ret_q, ret_d;     // WAIT state to resume after ERR
  logic [1:0]       winner_q, winner_d;
  logic             draw_q, draw_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic       cur_p2;
  logic [8:0] occupied;
  logic       reject;
  logic       line_complete;

  assign cur_p2 = (state_q == StP2Wait);

  for (genvar g = 0; g < 9; g++) begin : g_sq
    assign occupied[g]     = (board_q[g] != CELL_EMPTY);
    assign board_placed[g] = cur_pos[g] ? player_code(cur_p2) : board_q[g];
  end

  // Non-one-hot cursors and occupied squares are rejected even if the
  // external checker misses them, so a square is never overwritten.
  assign reject = illegal || !$onehot(cur_pos) || (|(cur_pos & occupied));

  ttt_win_detect u_win_detect (
    .board        (board_q),
    .code         (player_code(last_q)),
    .line_complete(line_complete)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StP1Wait;
      board_q    <= '0;
      move_cnt_q <= '0;
      last_q     <= 1'b0;
      ret_q      <= 1'b0;
      winner_q   <= CELL_EMPTY;
      draw_q     <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      move_cnt_q <= move_cnt_d;
      last_q     <= last_d;
      ret_q      <= ret_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Next-state and datapath update; new_game overrides everything.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    move_cnt_d = move_cnt_q;
    last_d     = last_q;
    ret_d      = ret_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    err_cnt_d  = err_cnt_q;
    if (new_game) begin
      state_d    = StP1Wait;
      board_d    = '0;
      move_cnt_d = '0;
      last_d     = 1'b0;
      ret_d      = 1'b0;
      winner_d   = CELL_EMPTY;
      draw_d     = 1'b0;
      err_cnt_d  = '0;
    end else begin
      unique case (state_q)
        StP1Wait, StP2Wait: begin
          if (confirm) begin
            if (reject) begin
              state_d   = StErr;
              err_cnt_d = ERR_LOAD;
              ret_d     = cur_p2;
            end else begin
              board_d    = board_placed;
              move_cnt_d = move_cnt_q + 4'd1;
              last_d     = cur_p2;
              state_d    = StEval;
            end
          end
        end
        StEval: begin
          if (line_complete) begin
            state_d  = StDone;
            winner_d = player_code(last_q);
          end else if (move_cnt_q == 4'd9) begin
            state_d = StDone;
            draw_d  = 1'b1;
          end else begin
            state_d = last_q ? StP1Wait : StP2Wait;
          end
        end
        StErr: begin
          if (err_cnt_q == '0) begin
            state_d = ret_q ? StP2Wait : StP1Wait;
          end else begin
            err_cnt_d = err_cnt_q - 1'b1;
          end
        end
        StDone: begin
        end
        default: state_d = StP1Wait;
      endcase
    end
  end

  // Moore outputs decoded from state and registered datapath.
  always_comb begin
    player1     = (state_q == StP1Wait);
    player2     = (state_q == StP2Wait);
    illegal_led = (state_q == StErr);
    game_over   = (state_q == StDone);
    winner      = winner_q;
    draw        = draw_q;
    move_cnt    = move_cnt_q;
    pos1        = board_q[0];
    pos2        = board_q[1];
    pos3        = board_q[2];
    pos4        = board_q[3];
    pos5        = board_q[4];
    pos6        = board_q[5];
    pos7        = board_q[6];
    pos8        = board_q[7];
    pos9        = board_q[8];
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Self-checking bench for ttt_turn_controller: a game-level model is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_ttt_turn_controller;

  localparam int unsigned ErrCycles = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] cur_pos = '0;
  logic       confirm = 1'b0;
  logic       illegal = 1'b0;
  logic       new_game = 1'b0;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
  logic       player1, player2, illegal_led, game_over, draw;
  logic [1:0] winner;
  logic [3:0] move_cnt;

  always #5 clk = ~clk;

  ttt_turn_controller #(
    .ERR_CYCLES(ErrCycles),
    .ERR_W     (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cur_pos    (cur_pos),
    .confirm    (confirm),
    .illegal    (illegal),
    .new_game   (new_game),
    .pos1       (pos1),
    .pos2       (pos2),
    .pos3       (pos3),
    .pos4       (pos4),
    .pos5       (pos5),
    .pos6       (pos6),
    .pos7       (pos7),
    .pos8       (pos8),
    .pos9       (pos9),
    .player1    (player1),
    .player2    (player2),
    .illegal_led(illegal_led),
    .game_over  (game_over),
    .winner     (winner),
    .draw       (draw),
    .move_cnt   (move_cnt)
  );

  logic [1:0] dpos [9];
  assign dpos[0] = pos1;
  assign dpos[1] = pos2;
  assign dpos[2] = pos3;
  assign dpos[3] = pos4;
  assign dpos[4] = pos5;
  assign dpos[5] = pos6;
  assign dpos[6] = pos7;
  assign dpos[7] = pos8;
  assign dpos[8] = pos9;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- game-level model ----------------
  int mb [9];       // 0 empty, 1 player1, 2 player2
  int mcnt;         // committed moves
  int mturn;        // whose move is awaited (0 = nobody)
  int msaved;       // player to resume after the error window
  int mlast;        // player who made the last move
  int merr;         // error-window cycles still to show
  int mwin;
  bit meval, mdone, mdraw;
  int m_ones, m_sq;

  int lines [8][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{1, 4, 7},
                       '{2, 5, 8}, '{3, 6, 9}, '{1, 5, 9}, '{3, 5, 7}};

  function automatic bit has_line(input int p);
    for (int l = 0; l < 8; l++) begin
      if (mb[lines[l][0]-1] == p && mb[lines[l][1]-1] == p && mb[lines[l][2]-1] == p)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mcnt = 0; mturn = 1; msaved = 0; mlast = 0; merr = 0; mwin = 0;
    meval = 0; mdone = 0; mdraw = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset || new_game) begin
      model_clear();
    end else if (meval) begin
      meval = 0;
      if (has_line(mlast)) begin
        mdone = 1; mwin = mlast;
      end else if (mcnt == 9) begin
        mdone = 1; mdraw = 1;
      end else begin
        mturn = 3 - mlast;
      end
    end else if (merr > 0) begin
      merr--;
      if (merr == 0) mturn = msaved;
    end else if (mturn != 0 && confirm) begin
      m_ones = 0; m_sq = 0;
      for (int i = 0; i < 9; i++) if (cur_pos[i]) begin m_ones++; m_sq = i; end
      if (illegal || m_ones != 1 || mb[m_sq] != 0) begin
        msaved = mturn; mturn = 0; merr = ErrCycles;
      end else begin
        mb[m_sq] = mturn; mcnt++; mlast = mturn; mturn = 0; meval = 1;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 9; i++) chk($sformatf("pos%0d", i + 1), 32'(dpos[i]), mb[i]);
      chk("player1", 32'(player1), 32'(mturn == 1));
      chk("player2", 32'(player2), 32'(mturn == 2));
      chk("illegal_led", 32'(illegal_led), 32'(merr > 0));
      chk("game_over", 32'(game_over), 32'(mdone));
      chk("winner", 32'(winner), mwin);
      chk("draw", 32'(draw), 32'(mdraw));
      chk("move_cnt", 32'(move_cnt), mcnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input logic [8:0] p, input logic c, input logic ill, input logic ng);
    @(negedge clk);
    cur_pos = p; confirm = c; illegal = ill; new_game = ng;
    @(negedge clk);
    confirm = 1'b0; illegal = 1'b0; new_game = 1'b0;
  endtask

  task automatic play(input int sq);
    logic [8:0] v;
    v = 9'b1 << (sq - 1);
    pulse(v, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_player1", 32'(player1), 1);
    chk("rst_player2", 32'(player2), 0);
    chk("rst_pos1", 32'(pos1), 0);
    chk("rst_move_cnt", 32'(move_cnt), 0);
    chk("rst_game_over", 32'(game_over), 0);

    // First move: board visible after the sampling edge, turn one later.
    pulse(9'h001, 1'b1, 1'b0, 1'b0);
    chk("first_pos1", 32'(pos1), 1);
    chk("first_move_cnt", 32'(move_cnt), 1);
    chk("first_p2_early", 32'(player2), 0);
    @(negedge clk);
    chk("first_p2_turn", 32'(player2), 1);

    // Player2 illegal attempt on an occupied square.
    pulse(9'h001, 1'b1, 1'b1, 1'b0);
    n = 0;
    repeat (10) begin
      if (illegal_led === 1'b1) n++;
      @(negedge clk);
    end
    chk("err_len", n, ErrCycles);
    chk("err_p2_back", 32'(player2), 1);
    chk("err_pos1", 32'(pos1), 1);
    chk("err_move_cnt", 32'(move_cnt), 1);

    // Player1 wins on the 1-5-9 diagonal.
    pulse(9'h000, 1'b0, 1'b0, 1'b1);
    play(1); play(2); play(5); play(3); play(9);
    chk("win_game_over", 32'(game_over), 1);
    chk("win_winner", 32'(winner), 1);
    chk("win_draw", 32'(draw), 0);
    chk("win_move_cnt", 32'(move_cnt), 5);
    pulse(9'h008, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("done_frozen_cnt", 32'(move_cnt), 5);
    chk("done_frozen_pos4", 32'(pos4), 0);

    // Full board without a line.
    pulse(9'h000, 1'b0, 1'b0, 1'b1);
    play(1); play(2); play(3); play(5); play(4); play(6); play(8); play(7); play(9);
    chk("draw_move_cnt", 32'(move_cnt), 9);
    chk("draw_draw", 32'(draw), 1);
    chk("draw_winner", 32'(winner), 0);
    chk("draw_game_over", 32'(game_over), 1);

    // new_game beats a simultaneous confirm.
    pulse(9'h000, 1'b0, 1'b0, 1'b1);
    play(1);
    pulse(9'h002, 1'b1, 1'b0, 1'b1);
    chk("ng_pos1", 32'(pos1), 0);
    chk("ng_pos2", 32'(pos2), 0);
    chk("ng_player1", 32'(player1), 1);
    chk("ng_move_cnt", 32'(move_cnt), 0);

    // Non-one-hot cursor is rejected even with illegal low.
    pulse(9'h003, 1'b1, 1'b0, 1'b0);
    chk("mh_led", 32'(illegal_led), 1);
    chk("mh_pos1", 32'(pos1), 0);
    chk("mh_pos2", 32'(pos2), 0);
    chk("mh_player1", 32'(player1), 0);
    pulse(9'h000, 1'b0, 1'b0, 1'b1);
    chk("ng_err_led", 32'(illegal_led), 0);
    chk("ng_err_player1", 32'(player1), 1);

    // Asynchronous reset while the move is being evaluated.
    pulse(9'h010, 1'b1, 1'b0, 1'b0);
    chk("eval_pos5", 32'(pos5), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pos5", 32'(pos5), 0);
    chk("arst_move_cnt", 32'(move_cnt), 0);
    chk("arst_player1", 32'(player1), 1);
    chk("arst_game_over", 32'(game_over), 0);
    @(negedge clk);
    reset = 1'b1;
    play(5);
    chk("post_rst_pos5", 32'(pos5), 1);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
